// File: rtl/descramble_lock_ctrl_if.sv
// PCS word bus between the gearbox, the lock controller and the descrambler bank.
// The controller takes the slave view: it consumes enc_* and produces out_*.
interface descramble_lock_ctrl_if;
  logic [31:0][63:0] enc_data;
  logic [31:0][1:0]  enc_sync;
  logic [31:0]       enc_vld;
  logic [31:0][63:0] out_data;
  logic [31:0][1:0]  out_sync;
  logic [31:0]       out_vld;

  modport master (
    output enc_data, enc_sync, enc_vld,
    input  out_data, out_sync, out_vld
  );

  modport slave (
    input  enc_data, enc_sync, enc_vld,
    output out_data, out_sync, out_vld
  );
endinterface

// File: rtl/descramble_lock_ctrl.sv
// Block-lock controller for the 32-word receive PCS bus: sync-header checking,
// lock FSM with gearbox slip requests, lock-gated datapath and error statistics.
module descramble_lock_ctrl #(
  parameter int LOCK_CNT   = 64,
  parameter int WINDOW     = 1024,
  parameter int UNLOCK_BAD = 65,
  parameter int SLIP_WAIT  = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  descramble_lock_ctrl_if.slave       bus,
  input  logic                        force_relock,
  input  logic                        clear_cnt,
  output logic                        block_lock,
  output logic                        slip,
  output logic [15:0]                 lock_loss_cnt,
  output logic [31:0]                 bad_hdr_cnt
);

  localparam logic [1:0] ST_TEST   = 2'd0;
  localparam logic [1:0] ST_SLIP   = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

  localparam int SH_W   = $clog2(LOCK_CNT + 33);
  localparam int WIN_W  = $clog2(WINDOW + 33);
  localparam int BAD_W  = $clog2(UNLOCK_BAD + 33);
  localparam int WAIT_W = (SLIP_WAIT > 1) ? $clog2(SLIP_WAIT) : 1;

  localparam logic [SH_W-1:0]   LOCK_THR   = SH_W'(LOCK_CNT);
  localparam logic [WIN_W-1:0]  WIN_THR    = WIN_W'(WINDOW);
  localparam logic [BAD_W-1:0]  BAD_THR    = BAD_W'(UNLOCK_BAD);
  localparam logic [WAIT_W-1:0] WAIT_LAST  = WAIT_W'(SLIP_WAIT - 1);

  logic [1:0]        state_reg, state_next;
  logic [SH_W-1:0]   sh_cnt_reg, sh_cnt_next;
  logic [WIN_W-1:0]  win_cnt_reg, win_cnt_next;
  logic [BAD_W-1:0]  bad_cnt_reg, bad_cnt_next;
  logic [WAIT_W-1:0] wait_cnt_reg, wait_cnt_next;
  logic              block_lock_reg, slip_reg, slip_next, loss_evt;
  logic [15:0]       lock_loss_reg;
  logic [31:0]       bad_hdr_reg;

  logic [31:0]       bad_word;
  logic [5:0]        n_vld, n_bad;
  logic [SH_W-1:0]   sh_sum;
  logic [WIN_W-1:0]  win_sum;
  logic [BAD_W-1:0]  bad_sum;
  logic [32:0]       bad_hdr_sum;

  // 2'b00 and 2'b11 are the invalid 64b/66b sync headers (even parity).
  generate
    for (genvar gi = 0; gi < 32; gi++) begin : g_hdr
      assign bad_word[gi] = bus.enc_vld[gi] & ~(bus.enc_sync[gi][1] ^ bus.enc_sync[gi][0]);
    end
  endgenerate

  always_comb begin
    n_vld = '0;
    n_bad = '0;
    for (int i = 0; i < 32; i++) begin
      n_vld = n_vld + {5'd0, bus.enc_vld[i]};
      n_bad = n_bad + {5'd0, bad_word[i]};
    end
  end

  // Counter widths leave 32 counts of headroom above each threshold, so sums never wrap.
  assign sh_sum      = sh_cnt_reg + SH_W'(n_vld);
  assign win_sum     = win_cnt_reg + WIN_W'(n_vld);
  assign bad_sum     = bad_cnt_reg + BAD_W'(n_bad);
  assign bad_hdr_sum = {1'b0, bad_hdr_reg} + {27'd0, n_bad};

  always_comb begin
    state_next    = state_reg;
    sh_cnt_next   = sh_cnt_reg;
    win_cnt_next  = win_cnt_reg;
    bad_cnt_next  = bad_cnt_reg;
    wait_cnt_next = wait_cnt_reg;
    slip_next     = 1'b0;
    loss_evt      = 1'b0;
    case (state_reg)
      ST_TEST: begin
        if (n_bad != 6'd0) begin
          state_next    = ST_SLIP;
          slip_next     = 1'b1;
          sh_cnt_next   = '0;
          wait_cnt_next = '0;
        end else if (sh_sum >= LOCK_THR) begin
          state_next   = ST_LOCKED;
          win_cnt_next = '0;
          bad_cnt_next = '0;
        end else begin
          sh_cnt_next = sh_sum;
        end
      end
      ST_SLIP: begin
        if (wait_cnt_reg == WAIT_LAST) begin
          state_next  = ST_TEST;
          sh_cnt_next = '0;
        end else begin
          wait_cnt_next = wait_cnt_reg + 1'b1;
        end
      end
      ST_LOCKED: begin
        if (bad_sum >= BAD_THR) begin
          state_next    = ST_SLIP;
          slip_next     = 1'b1;
          loss_evt      = 1'b1;
          wait_cnt_next = '0;
        end else if (win_sum >= WIN_THR) begin
          win_cnt_next = '0;
          bad_cnt_next = '0;
        end else begin
          win_cnt_next = win_sum;
          bad_cnt_next = bad_sum;
        end
      end
      default: begin
        state_next  = ST_TEST;
        sh_cnt_next = '0;
      end
    endcase
    // A forced relock silently restarts hunting: no slip, not counted as a loss.
    if (force_relock) begin
      state_next    = ST_TEST;
      sh_cnt_next   = '0;
      wait_cnt_next = '0;
      slip_next     = 1'b0;
      loss_evt      = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg      <= ST_TEST;
      sh_cnt_reg     <= '0;
      win_cnt_reg    <= '0;
      bad_cnt_reg    <= '0;
      wait_cnt_reg   <= '0;
      block_lock_reg <= 1'b0;
      slip_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      sh_cnt_reg     <= sh_cnt_next;
      win_cnt_reg    <= win_cnt_next;
      bad_cnt_reg    <= bad_cnt_next;
      wait_cnt_reg   <= wait_cnt_next;
      block_lock_reg <= (state_next == ST_LOCKED);
      slip_reg       <= slip_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || clear_cnt) begin
      lock_loss_reg <= '0;
      bad_hdr_reg   <= '0;
    end else begin
      if (state_reg == ST_LOCKED) begin
        bad_hdr_reg <= bad_hdr_sum[32] ? '1 : bad_hdr_sum[31:0];
      end
      if (loss_evt && (lock_loss_reg != 16'hFFFF)) begin
        lock_loss_reg <= lock_loss_reg + 16'd1;
      end
    end
  end

  // Valid is gated by the pre-update state, so the first forwarded beat follows lock.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      bus.out_data <= '0;
      bus.out_sync <= '0;
      bus.out_vld  <= '0;
    end else begin
      bus.out_data <= bus.enc_data;
      bus.out_sync <= bus.enc_sync;
      bus.out_vld  <= bus.enc_vld & {32{state_reg == ST_LOCKED}};
    end
  end

  assign block_lock    = block_lock_reg;
  assign slip          = slip_reg;
  assign lock_loss_cnt = lock_loss_reg;
  assign bad_hdr_cnt   = bad_hdr_reg;

endmodule
